alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Issue/operand stage directly upstream of the registered 32-bit ALU.
- Accepts decoded ALU instructions over a valid/ready handshake and reads operands from an internal 32x32 register file. Resolves read-after-write hazards against the ALU's one-cycle registered latency by stalling and bypassing.
- Drives registered A/B/ALUOp into the ALU and writes ALU Result back to the register file.

Parameters:
- XLEN, 32, datapath width; must match ALU width.
- RF_DEPTH, 32, register count; x0 hard-wired to zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  stage accepts instruction this cycle
- in_alu_op  in  3  ALU op: 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 AND, 110 OR, 111 XOR
- in_rs1  in  5  source register A
- in_rs2  in  5  source register B; ignored when in_use_imm=1
- in_rd  in  5  destination register
- in_imm  in  XLEN  immediate
- in_use_imm  in  1  B operand = in_imm
- alu_a  out  XLEN  registered operand A to ALU
- alu_b  out  XLEN  registered operand B to ALU
- alu_op  out  3  registered ALUOp to ALU
- issue_valid  out  1  alu_a/b/op carry a real instruction
- alu_result  in  XLEN  ALU Result
- wb_valid  out  1  writeback occurring this cycle
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  writeback data (= alu_result)
- dbg_addr  in  5  debug read address
- dbg_data  out  XLEN  register file contents at dbg_addr, combinational, no bypass

Behaviour:
- Reset (async, rst_n low):
  - All registers cleared to 0.
  - alu_a, alu_b, alu_op, issue_valid, wb_valid, wb_rd cleared to 0.
  - Pipeline tracking (s1, s2) cleared to invalid.
- Pipeline tracking, per accepted instruction:
  - Accept at edge T (in_valid & in_ready): operands registered onto alu_*; s1 = {valid, rd}.
  - Edge T+1: ALU captures. s1 moves to s2.
  - Cycle after T+1: alu_result holds the instruction's result; wb_valid=1, wb_rd=s2.rd, wb_data=alu_result.
  - Edge T+2: register file written if s2.rd != 0.
- Operand read, for each source rs:
  - rs == 0 -> 0.
  - Else if s2 valid and rs == s2.rd -> alu_result (bypass).
  - Else -> register file.
- Hazard: in_ready = 0 when in_valid and s1 valid, s1.rd != 0, and (in_rs1 == s1.rd, or in_rs2 == s1.rd with in_use_imm=0). Otherwise in_ready = 1.
  - Back-to-back dependent instructions therefore incur exactly one bubble.
- B operand:
  - B = in_use_imm ? in_imm : rs2 value.
  - For SLL/SRL/SRA, B is zero-extended from bits [4:0] before registering; the ALU shifts by the full B.
- Bubble (no accept):
  - alu_a, alu_b, alu_op hold their previous values; issue_valid = 0.
  - s1 becomes invalid, so no writeback two cycles later.
- Writes to rd = 0:
  - The instruction still issues and tracks normally.
  - The register file is not written and the stage never stalls on rd 0.
  - wb_valid still asserts, with wb_rd = 0.
- Simultaneous writeback and read of the same register: the bypass returns the new value. dbg_data returns the old value until the edge.
- rst_n asserted mid-stream: in-flight s1/s2 instructions are discarded. No writeback follows deassertion.
- Throughput: one instruction per cycle when there are no hazards. Issue-to-writeback latency is 2 edges.

Test Plan:
- Reset, then dbg_data sweep over addresses 0..31 -> all 0; in_ready=1; issue_valid=0; wb_valid=0.
- Issue ADD x1 = x0 + imm 5 (in_use_imm=1) -> alu_a=0, alu_b=5, alu_op=000. Two edges later wb_valid=1, wb_rd=1, wb_data=5. Afterwards dbg_data(1)=5.
- ADDI x1=7 immediately followed by SUB x2 = x1 - x0 -> in_ready=0 for exactly one cycle; SUB then issues with alu_a=7 via bypass; x2=7.
- x1=3 written, then one independent instruction, then AND x3 = x1 & x1 -> no stall; alu_a=3 taken from the alu_result bypass.
- SLL with in_imm=0x0000_0021 -> alu_b=1; A=1 gives result 2.
- ADDI x0=9 then read x0 -> operand 0, no stall, dbg_data(0)=0.
- Assert rst_n low one cycle after issuing ADDI x4=9 -> wb_valid stays 0 and dbg_data(4)=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue/operand stage feeding a registered ALU with one cycle of latency.
// Holds the 32-entry register file, resolves RAW hazards by a one-cycle
// stall against the instruction just issued, and by bypassing alu_result
// for the instruction currently in writeback.
module alu_operand_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_op,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic            issue_valid,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] rf [RF_DEPTH];

    // s1: instruction whose operands sit on alu_* (ALU captures next edge).
    // s2 is held directly in wb_valid / wb_rd.
    logic            s1_valid;
    logic [4:0]      s1_rd;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] b_sel;
    logic [XLEN-1:0] b_next;
    logic            hazard;
    logic            accept;

    // Operand A: x0 is zero, writeback-stage result bypassed, else register file.
    always_comb begin
        rs1_val = '0;
        if (in_rs1 != 5'd0) begin
            if (wb_valid && (in_rs1 == wb_rd)) begin
                rs1_val = alu_result;
            end else begin
                rs1_val = rf[in_rs1];
            end
        end
    end

    // Operand B register source, same priority as operand A.
    always_comb begin
        rs2_val = '0;
        if (in_rs2 != 5'd0) begin
            if (wb_valid && (in_rs2 == wb_rd)) begin
                rs2_val = alu_result;
            end else begin
                rs2_val = rf[in_rs2];
            end
        end
    end

    // B mux; shift ops only keep the 5-bit shift amount.
    always_comb begin
        b_sel  = in_use_imm ? in_imm : rs2_val;
        b_next = b_sel;
        if (in_alu_op inside {3'b010, 3'b011, 3'b100}) begin
            b_next = {{(XLEN-5){1'b0}}, b_sel[4:0]};
        end
    end

    // Stall when a source depends on the instruction issued last cycle,
    // whose result is not yet on alu_result. rd 0 never stalls.
    always_comb begin
        hazard = s1_valid && (s1_rd != 5'd0) &&
                 ((in_rs1 == s1_rd) || (!in_use_imm && (in_rs2 == s1_rd)));
        in_ready = !(in_valid && hazard);
        accept   = in_valid && in_ready;
    end

    // Issue registers and pipeline tracking; operands hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            issue_valid <= 1'b0;
            s1_valid    <= 1'b0;
            s1_rd       <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
        end else begin
            issue_valid <= accept;
            s1_valid    <= accept;
            wb_valid    <= s1_valid;
            wb_rd       <= s1_rd;
            if (accept) begin
                alu_a  <= rs1_val;
                alu_b  <= b_next;
                alu_op <= in_alu_op;
                s1_rd  <= in_rd;
            end
        end
    end

    // Register file write at the end of the writeback cycle; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_valid && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= alu_result;
        end
    end

    assign wb_data  = alu_result;
    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, reset
// sequences, and randomized traffic against an architectural register model.
`timescale 1ns/1ps
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        issue_valid;
    logic [31:0] alu_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_operand_stage #(.XLEN(32), .RF_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .issue_valid(issue_valid),
        .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0: ref_alu = a + b;
            3'd1: ref_alu = a - b;
            3'd2: ref_alu = a << b;
            3'd3: ref_alu = a >> b;
            3'd4: ref_alu = $signed(a) >>> b;
            3'd5: ref_alu = a & b;
            3'd6: ref_alu = a | b;
            default: ref_alu = a ^ b;
        endcase
    endfunction

    // External registered ALU.
    always @(posedge clk) alu_result <= ref_alu(alu_a, alu_b, alu_op);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: arch = state after all issued instructions,
    // commit = what the register file should show right now.
    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic [31:0] arch   [32];
    logic [31:0] commit [32];
    wb_t         wbq[$];
    bit          pend_v;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    bit          last_v;
    logic [4:0]  last_rd;
    logic [31:0] exp_a, exp_b;
    logic [2:0]  exp_op;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            arch[i]   = '0;
            commit[i] = '0;
        end
        wbq.delete();
        pend_v = 1'b0;
        last_v = 1'b0;
        last_rd = '0;
        exp_a = '0;
        exp_b = '0;
        exp_op = '0;
    endtask

    function automatic logic [31:0] src(input logic [4:0] r);
        src = (r == 5'd0) ? 32'd0 : arch[r];
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then
    // check registered outputs just after the posedge.
    task automatic step(input bit v, input logic [2:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input bit ui, output bit acc);
        bit          haz;
        logic [31:0] a, b, res;
        wb_t         e;
        @(negedge clk);
        in_valid = v; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_imm = imm; in_use_imm = ui;
        dbg_addr = 5'($urandom_range(0, 31));
        #1;
        check("dbg_data", dbg_data, commit[dbg_addr]);
        if (pend_v) begin
            if (pend_rd != 5'd0) commit[pend_rd] = pend_data;
            pend_v = 1'b0;
        end
        haz = v && last_v && (last_rd != 5'd0) &&
              ((rs1 == last_rd) || (!ui && (rs2 == last_rd)));
        check("in_ready", 32'(in_ready), 32'(!haz));
        acc = v && !haz;
        if (acc) begin
            a = src(rs1);
            b = ui ? imm : src(rs2);
            if (op inside {3'd2, 3'd3, 3'd4}) b = b % 32;
            res = ref_alu(a, b, op);
            exp_a = a; exp_b = b; exp_op = op;
            if (rd != 5'd0) arch[rd] = res;
            e.due = cyc + 2; e.rd = rd; e.data = res;
            wbq.push_back(e);
        end
        last_v = acc;
        last_rd = rd;
        @(posedge clk);
        #1;
        check("issue_valid", 32'(issue_valid), 32'(acc));
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_op", 32'(alu_op), 32'(exp_op));
        if (wbq.size() > 0 && wbq[0].due == cyc) begin
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_rd", 32'(wb_rd), 32'(wbq[0].rd));
            check("wb_data", wb_data, wbq[0].data);
            pend_v = 1'b1; pend_rd = wbq[0].rd; pend_data = wbq[0].data;
            void'(wbq.pop_front());
        end else begin
            check("wb_valid_idle", 32'(wb_valid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, acc);
    endtask

    task automatic sweep(input string name);
        in_valid = 1'b0;
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            check(name, dbg_data, commit[r]);
        end
    endtask

    task automatic reg_at(input logic [4:0] r, input logic [31:0] v);
        dbg_addr = r;
        #1;
        check("dbg_reg", dbg_data, v);
    endtask

    // Assert reset across one posedge, check cleared outputs, restart model.
    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        clear_model();
        @(posedge clk);
        #1;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        bit          ui;
        logic [31:0] ea, eb;
        int          stalls;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit acc;
        int st;
        logic [2:0]  r_op;
        logic [4:0]  r_rs1, r_rs2, r_rd;
        logic [31:0] r_imm;
        bit          r_ui, r_v, pending;

        //          op    rs1    rs2    rd     imm           ui  exp_a  exp_b      stalls
        tbl[0]  = '{3'd0, 5'd0,  5'd0,  5'd1,  32'd7,        1, 32'd0, 32'd7,     0};
        tbl[1]  = '{3'd1, 5'd1,  5'd0,  5'd2,  32'd0,        0, 32'd7, 32'd0,     1};
        tbl[2]  = '{3'd0, 5'd0,  5'd0,  5'd1,  32'd3,        1, 32'd0, 32'd3,     0};
        tbl[3]  = '{3'd0, 5'd0,  5'd0,  5'd5,  32'd1,        1, 32'd0, 32'd1,     0};
        tbl[4]  = '{3'd5, 5'd1,  5'd1,  5'd3,  32'd0,        0, 32'd3, 32'd3,     0};
        tbl[5]  = '{3'd2, 5'd5,  5'd0,  5'd6,  32'h21,       1, 32'd1, 32'd1,     0};
        tbl[6]  = '{3'd0, 5'd0,  5'd0,  5'd0,  32'd9,        1, 32'd0, 32'd9,     0};
        tbl[7]  = '{3'd0, 5'd0,  5'd0,  5'd7,  32'd0,        0, 32'd0, 32'd0,     0};
        tbl[8]  = '{3'd4, 5'd2,  5'd0,  5'd8,  32'hFFFF_FFE4, 1, 32'd7, 32'd4,    0};
        tbl[9]  = '{3'd6, 5'd3,  5'd8,  5'd10, 32'd0,        0, 32'd3, 32'd0,     1};
        tbl[10] = '{3'd0, 5'd1,  5'd10, 5'd11, 32'h100,      1, 32'd3, 32'h100,   0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_alu_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_use_imm = 1'b0; dbg_addr = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_issue_valid", 32'(issue_valid), 32'd0);
        check("init_wb_valid", 32'(wb_valid), 32'd0);
        sweep("init_dbg");

        // ADD x1 = x0 + 5, then watch its writeback.
        step(1'b1, 3'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, acc);
        check("addi_alu_a", alu_a, 32'd0);
        check("addi_alu_b", alu_b, 32'd5);
        check("addi_alu_op", 32'(alu_op), 32'd0);
        idle(1);
        check("addi_wb_valid", 32'(wb_valid), 32'd1);
        check("addi_wb_rd", 32'(wb_rd), 32'd1);
        check("addi_wb_data", wb_data, 32'd5);
        idle(1);
        reg_at(5'd1, 32'd5);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            st = 0;
            acc = 1'b0;
            for (int t = 0; t < 4 && !acc; t++) begin
                step(1'b1, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].ui, acc);
                if (!acc) st++;
            end
            check($sformatf("vec%0d_accepted", i), 32'(acc), 32'd1);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'(tbl[i].stalls));
            check($sformatf("vec%0d_alu_a", i), alu_a, tbl[i].ea);
            check($sformatf("vec%0d_alu_b", i), alu_b, tbl[i].eb);
        end
        idle(3);
        reg_at(5'd0, 32'd0);
        reg_at(5'd1, 32'd3);
        reg_at(5'd2, 32'd7);
        reg_at(5'd3, 32'd3);
        reg_at(5'd6, 32'd2);
        reg_at(5'd8, 32'd0);
        reg_at(5'd11, 32'h103);

        // Reset one cycle after issuing ADDI x4 = 9: nothing may write back.
        step(1'b1, 3'd0, 5'd0, 5'd0, 5'd4, 32'd9, 1'b1, acc);
        pulse_reset();
        idle(3);
        reg_at(5'd4, 32'd0);
        reg_at(5'd1, 32'd0);

        // Randomized traffic; an offered instruction is held until accepted.
        pending = 1'b0;
        r_op = '0; r_rs1 = '0; r_rs2 = '0; r_rd = '0; r_imm = '0; r_ui = 1'b0; r_v = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pending) begin
                r_v   = ($urandom_range(0, 9) < 8);
                r_op  = 3'($urandom_range(0, 7));
                r_rs1 = 5'($urandom_range(0, 7));
                r_rs2 = 5'($urandom_range(0, 7));
                r_rd  = 5'($urandom_range(0, 7));
                r_imm = $urandom;
                r_ui  = $urandom_range(0, 1);
            end
            step(r_v, r_op, r_rs1, r_rs2, r_rd, r_imm, r_ui, acc);
            pending = r_v && !acc;
        end
        idle(4);
        sweep("final_dbg");
        for (int r = 0; r < 32; r++) begin
            reg_at(5'(r), arch[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
